// File: rtl/ct_rtu_pst_preg_freelist_pkg.sv
// Shared rtu constants and the modulo-96 pointer increment used by the preg free list.
package ct_rtu_pst_preg_freelist_pkg;

  localparam int PREG_NUM     = 96;  // physical registers / free-list entries
  localparam int PREG_W       = 7;   // preg index and pointer width
  localparam int ARCH_REG_NUM = 32;  // pregs 0..31 carry architectural state out of reset

  // Advance a list pointer by 0..3 and wrap at PREG_NUM. The list depth is not a
  // power of two, so a plain carry-out wrap is not enough.
  function automatic logic [PREG_W-1:0] ptr_inc(input logic [PREG_W-1:0] ptr,
                                               input logic [1:0]        step);
    logic [PREG_W:0] sum;
    sum = {1'b0, ptr} + {{(PREG_W-1){1'b0}}, step};
    if (sum >= (PREG_W+1)'(PREG_NUM))
      sum = sum - (PREG_W+1)'(PREG_NUM);
    return sum[PREG_W-1:0];
  endfunction

endpackage

// File: rtl/ct_rtu_pst_preg_freelist.sv
// Circular free list of physical register numbers: one pop per cycle to the
// allocator, up to two releases per cycle from retire (port 0 ordered first).
module ct_rtu_pst_preg_freelist
  import ct_rtu_pst_preg_freelist_pkg::*;
#(
  parameter int DEPTH         = PREG_NUM,
  parameter int PTR_W         = PREG_W,     // ptr_inc is sized by PREG_W; keep them equal
  parameter int RST_FREE_BASE = ARCH_REG_NUM
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst_b,
  input  logic             idu_rtu_alloc_req,
  output logic             rtu_idu_alloc_vld,
  output logic [PTR_W-1:0] rtu_idu_alloc_preg,
  input  logic             retire_rel0_vld,
  input  logic [PTR_W-1:0] retire_rel0_preg,
  input  logic             retire_rel1_vld,
  input  logic [PTR_W-1:0] retire_rel1_preg,
  output logic [PTR_W-1:0] rtu_freelist_cnt,
  output logic             rtu_freelist_err
);

  localparam logic [PTR_W-1:0] RST_CNT = PTR_W'(DEPTH - RST_FREE_BASE);

  logic [DEPTH-1:0][PTR_W-1:0] entry;
  logic [PTR_W-1:0]            rptr, wptr, cnt;
  logic [PTR_W-1:0]            rptr_p1, wptr_p1, wptr_p2;
  logic [PTR_W-1:0]            wdat0, cnt_nxt;
  logic [PTR_W:0]              cnt_sum;
  logic                        err;
  logic                        pop, under, ovf, bad_idx, we0, we1;

  assign rptr_p1 = ptr_inc(rptr, 2'd1);
  assign wptr_p1 = ptr_inc(wptr, 2'd1);
  assign wptr_p2 = ptr_inc(wptr, 2'd2);

  // Head of list is read straight from the flops; no bypass from releases.
  assign rtu_idu_alloc_vld  = (cnt != '0);
  assign rtu_idu_alloc_preg = entry[rptr];
  assign rtu_freelist_cnt   = cnt;
  assign rtu_freelist_err   = err;

  assign pop   = idu_rtu_alloc_req &  rtu_idu_alloc_vld;
  assign under = idu_rtu_alloc_req & ~rtu_idu_alloc_vld;

  // One extra bit so the over-release check sees counts above 96.
  assign cnt_sum = {1'b0, cnt}
                 + {{PTR_W{1'b0}}, retire_rel0_vld}
                 + {{PTR_W{1'b0}}, retire_rel1_vld}
                 - {{PTR_W{1'b0}}, pop};
  assign ovf     = (cnt_sum > (PTR_W+1)'(DEPTH));
  // On overflow every release of the cycle is dropped but the pop still counts.
  assign cnt_nxt = ovf ? (cnt - {{(PTR_W-1){1'b0}}, pop}) : cnt_sum[PTR_W-1:0];

  assign bad_idx = (retire_rel0_vld & (retire_rel0_preg >= PTR_W'(DEPTH)))
                 | (retire_rel1_vld & (retire_rel1_preg >= PTR_W'(DEPTH)));

  // A lone port-1 release takes the wptr slot just like a lone port-0 release.
  assign we0   = ~ovf & (retire_rel0_vld | retire_rel1_vld);
  assign we1   = ~ovf &  retire_rel0_vld & retire_rel1_vld;
  assign wdat0 = retire_rel0_vld ? retire_rel0_preg : retire_rel1_preg;

  // Entry array: reset image holds pregs 32..95 in slots 0..63.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      for (int i = 0; i < DEPTH; i++)
        entry[i] <= (i < DEPTH - RST_FREE_BASE) ? PTR_W'(RST_FREE_BASE + i) : '0;
    end else begin
      if (we0) entry[wptr]    <= wdat0;
      if (we1) entry[wptr_p1] <= retire_rel1_preg;
    end
  end

  // Pointers, count and the sticky error flag.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rptr <= '0;
      wptr <= RST_CNT;
      cnt  <= RST_CNT;
      err  <= 1'b0;
    end else begin
      if (pop) rptr <= rptr_p1;
      if (we1)      wptr <= wptr_p2;
      else if (we0) wptr <= wptr_p1;
      cnt <= cnt_nxt;
      err <= err | under | ovf | bad_idx;
    end
  end

endmodule

// File: tb/tb_ct_rtu_pst_preg_freelist.sv
// Directed bench for the preg free list: table of per-cycle vectors plus
// hand-written sequences for wrap, empty, overflow and async reset cases.
module tb_ct_rtu_pst_preg_freelist;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       req;
  logic       vld;
  logic [6:0] preg;
  logic       r0v, r1v;
  logic [6:0] r0p, r1p;
  logic [6:0] cnt;
  logic       err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ct_rtu_pst_preg_freelist dut (
    .forever_cpuclk     (clk),
    .cpurst_b           (rst_b),
    .idu_rtu_alloc_req  (req),
    .rtu_idu_alloc_vld  (vld),
    .rtu_idu_alloc_preg (preg),
    .retire_rel0_vld    (r0v),
    .retire_rel0_preg   (r0p),
    .retire_rel1_vld    (r1v),
    .retire_rel1_preg   (r1p),
    .rtu_freelist_cnt   (cnt),
    .rtu_freelist_err   (err)
  );

  typedef struct {
    logic       req;
    logic       r0v;
    logic [6:0] r0p;
    logic       r1v;
    logic [6:0] r1p;
    logic       evld;
    logic [6:0] epreg;
    logic [6:0] ecnt;
    logic       eerr;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Compare all outputs; preg only matters while vld is expected high.
  task automatic chk_out(input string nm, input logic ev, input int ep, input int ec, input logic ee);
    chk({nm, ".vld"}, {31'b0, vld}, int'(ev));
    if (ev) chk({nm, ".preg"}, {25'b0, preg}, ep);
    chk({nm, ".cnt"}, {25'b0, cnt}, ec);
    chk({nm, ".err"}, {31'b0, err}, int'(ee));
  endtask

  // Drive one cycle of inputs across a rising edge, then idle them at edge+1.
  task automatic step(input logic q, input logic a_v, input logic [6:0] a_p,
                      input logic b_v, input logic [6:0] b_p);
    req = q; r0v = a_v; r0p = a_p; r1v = b_v; r1p = b_p;
    @(posedge clk); #1;
    req = 1'b0; r0v = 1'b0; r0p = '0; r1v = 1'b0; r1p = '0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_b = 1'b0;
    #2;
    rst_b = 1'b1;
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 7'd0, 1'b0, 7'd0);
  endtask

  task automatic rel_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 7'(i), 1'b0, 7'd0);
  endtask

  initial begin
    req = 1'b0; r0v = 1'b0; r0p = '0; r1v = 1'b0; r1p = '0;
    rst_b = 1'b0;

    //                 req   r0v   r0p     r1v   r1p     vld   preg    cnt     err
    tbl[0] = '{1'b1, 1'b0, 7'd0,   1'b0, 7'd0,  1'b1, 7'd33, 7'd63, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 7'd10,  1'b0, 7'd0,  1'b1, 7'd34, 7'd63, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 7'd0,   1'b1, 7'd11, 1'b1, 7'd34, 7'd64, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 7'd12,  1'b1, 7'd13, 1'b1, 7'd35, 7'd65, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 7'd0,   1'b0, 7'd0,  1'b1, 7'd35, 7'd65, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 7'd100, 1'b0, 7'd0,  1'b1, 7'd35, 7'd66, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 7'd0,   1'b0, 7'd0,  1'b1, 7'd36, 7'd65, 1'b1};

    // Reset image visible while reset is held.
    #12;
    chk_out("in_reset", 1'b1, 32, 64, 1'b0);
    rst_b = 1'b1;

    // Table-driven single cycles from the reset image.
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].req, tbl[i].r0v, tbl[i].r0p, tbl[i].r1v, tbl[i].r1p);
      chk_out($sformatf("tbl%0d", i), tbl[i].evld, int'(tbl[i].epreg), int'(tbl[i].ecnt), tbl[i].eerr);
    end

    // 64 back-to-back pops drain 32..95 in order.
    do_reset();
    chk_out("post_reset", 1'b1, 32, 64, 1'b0);
    for (int i = 0; i < 64; i++) begin
      chk({"drain.preg"}, {25'b0, preg}, 32 + i);
      step(1'b1, 1'b0, 7'd0, 1'b0, 7'd0);
    end
    chk_out("drained", 1'b0, 0, 0, 1'b0);

    // Empty list: release 40 with a pop request; no bypass, pop flags error.
    req = 1'b1; r0v = 1'b1; r0p = 7'd40;
    #1;
    chk_out("empty_T", 1'b0, 0, 0, 1'b0);
    step(1'b1, 1'b1, 7'd40, 1'b0, 7'd0);
    chk_out("empty_T1", 1'b1, 40, 1, 1'b1);

    // Dual release across the 95 -> 0 wrap.
    do_reset();
    pop_n(64);
    rel_n(31);
    chk_out("pre_wrap", 1'b1, 0, 31, 1'b0);
    step(1'b0, 1'b1, 7'd5, 1'b1, 7'd7);
    chk_out("wrap_rel", 1'b1, 0, 33, 1'b0);
    pop_n(31);
    chk_out("wrap_pop5", 1'b1, 5, 2, 1'b0);
    pop_n(1);
    chk_out("wrap_pop7", 1'b1, 7, 1, 1'b0);
    pop_n(1);
    chk_out("wrap_empty", 1'b0, 0, 0, 1'b0);

    // Pop plus dual release at cnt = 10.
    do_reset();
    pop_n(54);
    chk_out("cnt10", 1'b1, 86, 10, 1'b0);
    step(1'b1, 1'b1, 7'd1, 1'b1, 7'd2);
    chk_out("pop_dual", 1'b1, 87, 11, 1'b0);
    pop_n(9);
    chk_out("pop_dual_r0", 1'b1, 1, 2, 1'b0);
    pop_n(1);
    chk_out("pop_dual_r1", 1'b1, 2, 1, 1'b0);

    // Overflow at cnt = 95 without pop: releases dropped, wptr held.
    do_reset();
    rel_n(31);
    chk_out("cnt95", 1'b1, 32, 95, 1'b0);
    step(1'b0, 1'b1, 7'd50, 1'b1, 7'd51);
    chk_out("ovf_drop", 1'b1, 32, 95, 1'b1);
    step(1'b0, 1'b1, 7'd60, 1'b0, 7'd0);
    chk_out("ovf_fill", 1'b1, 32, 96, 1'b1);
    pop_n(95);
    chk_out("ovf_slot95", 1'b1, 60, 1, 1'b1);

    // Same overflow-sized release with a concurrent pop is legal.
    do_reset();
    rel_n(31);
    step(1'b1, 1'b1, 7'd50, 1'b1, 7'd51);
    chk_out("full_pop", 1'b1, 33, 96, 1'b0);

    // Asynchronous reset mid-stream at cnt = 17 with err set.
    do_reset();
    pop_n(48);
    step(1'b0, 1'b1, 7'd99, 1'b0, 7'd0);
    chk_out("cnt17", 1'b1, 80, 17, 1'b1);
    #2;
    rst_b = 1'b0;
    #1;
    chk_out("async_rst", 1'b1, 32, 64, 1'b0);
    #2;
    rst_b = 1'b1;
    step(1'b1, 1'b0, 7'd0, 1'b0, 7'd0);
    chk_out("after_rst", 1'b1, 33, 63, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
